// File: rtl/fetch_pc_unit_if.sv
// Fetch-PC unit bus: D-stage redirect controls, hazard stall, CP0 redirect
// inputs, and the fetch PC / next-PC / fetch-exception outputs.
// master = pipeline side that drives controls, slave = fetch_pc_unit.
interface fetch_pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic [2:0]       mode;
  logic             cmpRes;
  logic [25:0]      imm26_D;
  logic [WIDTH-1:0] PC_D;
  logic [WIDTH-1:0] regRD1_D;
  logic             excReq;
  logic             eret_D;
  logic [WIDTH-1:0] EPC;
  logic [WIDTH-1:0] PC_F;
  logic [WIDTH-1:0] PC_next;
  logic             excAdEL_F;

  modport master (
    output stall, mode, cmpRes, imm26_D, PC_D, regRD1_D, excReq, eret_D, EPC,
    input  PC_F, PC_next, excAdEL_F
  );

  modport slave (
    input  stall, mode, cmpRes, imm26_D, PC_D, regRD1_D, excReq, eret_D, EPC,
    output PC_F, PC_next, excAdEL_F
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter. Holds PC_F and selects the next fetch address
// from sequential fetch, branch, J-type, register jump, exception handler
// entry and eret return.
// Optional feature macro: FETCH_CHECK_EN -- when defined, excAdEL_F flags a
// misaligned or out-of-window PC_F; otherwise excAdEL_F is tied to 0.
module fetch_pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [WIDTH-1:0] IM_LO      = 32'h0000_3000,
  parameter logic [WIDTH-1:0] IM_HI      = 32'h0000_6ffc
) (
  input  logic            clk,
  input  logic            reset,
  fetch_pc_unit_if.slave  bus
);

  localparam logic [2:0] MODE_BRANCH = 3'd1;
  localparam logic [2:0] MODE_JTYPE  = 3'd2;
  localparam logic [2:0] MODE_JREG   = 3'd3;

  // The J-type splice keeps PC_D[WIDTH-1:28]; an inverted fetch window is
  // a parameterisation mistake in either build.
  if (WIDTH < 32) begin : g_bad_width
    $error("fetch_pc_unit: WIDTH must be >= 32");
  end
  if (IM_HI < IM_LO) begin : g_bad_window
    $error("fetch_pc_unit: IM_HI below IM_LO");
  end

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] seq_tgt;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] br_off;

  // Word offset of the branch: sign-extended imm16 scaled by 4.
  assign br_off  = {{(WIDTH-18){bus.imm26_D[15]}}, bus.imm26_D[15:0], 2'b00};
  assign seq_tgt = pc_q + WIDTH'(4);
  assign br_tgt  = bus.PC_D + WIDTH'(4) + br_off;
  assign j_tgt   = {bus.PC_D[WIDTH-1:28], bus.imm26_D, 2'b00};

  // Next-PC select: CP0 redirects beat the stall so a frozen pipeline can
  // still take an exception or return from one.
  always_comb begin
    pc_d = seq_tgt;
    if (bus.excReq)      pc_d = HANDLER_PC;
    else if (bus.eret_D) pc_d = bus.EPC;
    else if (bus.stall)  pc_d = pc_q;
    else begin
      unique case (bus.mode)
        MODE_BRANCH: pc_d = bus.cmpRes ? br_tgt : seq_tgt;
        MODE_JTYPE:  pc_d = j_tgt;
        MODE_JREG:   pc_d = bus.regRD1_D;  // no alignment masking on purpose
        default:     pc_d = seq_tgt;
      endcase
    end
  end

  // PC register; reset is asynchronous and overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign bus.PC_F    = pc_q;
  assign bus.PC_next = pc_d;

`ifdef FETCH_CHECK_EN
  // Fetch address error: misaligned or outside instruction memory.
  assign bus.excAdEL_F = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
`else
  assign bus.excAdEL_F = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: the driver pushes the expected PC_F /
// excAdEL_F for each applied vector, the monitor pops and compares one entry
// per cycle on the falling edge.
module tb_fetch_pc_unit;
  localparam int W = 32;

  typedef struct {
    string        name;
    logic [W-1:0] pc;
    logic         flag;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  fetch_pc_unit_if #(.WIDTH(W)) bus ();

  fetch_pc_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector now (no wait) and queue its post-edge expectation.
  // flag_chk is the expected flag of a fetch-check build.
  task automatic drive_vec(input string name, input logic st, input logic [2:0] md,
                           input logic cmp, input logic [25:0] imm,
                           input logic [W-1:0] pcd, input logic [W-1:0] rd1,
                           input logic exc, input logic er, input logic [W-1:0] epc,
                           input logic [W-1:0] exp_pc, input logic flag_chk);
    exp_t e;
    bus.stall = st; bus.mode = md; bus.cmpRes = cmp; bus.imm26_D = imm;
    bus.PC_D = pcd; bus.regRD1_D = rd1; bus.excReq = exc; bus.eret_D = er;
    bus.EPC = epc;
    e.name = name;
    e.pc   = exp_pc;
`ifdef FETCH_CHECK_EN
    e.flag = flag_chk;
`else
    e.flag = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic step(input string name, input logic st, input logic [2:0] md,
                      input logic cmp, input logic [25:0] imm,
                      input logic [W-1:0] pcd, input logic [W-1:0] rd1,
                      input logic exc, input logic er, input logic [W-1:0] epc,
                      input logic [W-1:0] exp_pc, input logic flag_chk);
    @(negedge clk); #1;
    drive_vec(name, st, md, cmp, imm, pcd, rd1, exc, er, epc, exp_pc, flag_chk);
  endtask

  task automatic check_now(input string name, input logic [W-1:0] exp_pc);
    n_vec++;
    if (bus.PC_F !== exp_pc || bus.excAdEL_F !== 1'b0) begin
      n_err++;
      $display("FAIL %s: PC_F=%h flag=%b, want PC_F=%h flag=0", name, bus.PC_F,
               bus.excAdEL_F, exp_pc);
    end
  endtask

  // Monitor: one expectation per cycle while any are pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.PC_F !== e.pc || bus.excAdEL_F !== e.flag) begin
          n_err++;
          $display("FAIL %s: PC_F=%h flag=%b, want PC_F=%h flag=%b", e.name,
                   bus.PC_F, bus.excAdEL_F, e.pc, e.flag);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0;
    bus.stall = 0; bus.mode = 3'd0; bus.cmpRes = 0; bus.imm26_D = '0;
    bus.PC_D = '0; bus.regRD1_D = '0; bus.excReq = 0; bus.eret_D = 0; bus.EPC = '0;
    repeat (3) @(posedge clk);
    #1 check_now("reset_hold", 32'h3000);

    // release between edges; first edge takes seq
    @(negedge clk); #1;
    reset = 1'b1;
    drive_vec("seq0", 0, 3'd0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h3004, 0);
    step("seq1",      0, 3'd0, 0, 26'h0,      32'h0,    32'h0,    0, 0, 32'h0, 32'h3008, 0);
    step("br_taken",  0, 3'd1, 1, 26'hFFFE,   32'h3010, 32'h0,    0, 0, 32'h0, 32'h300C, 0);
    step("br_ntaken", 0, 3'd1, 0, 26'hFFFE,   32'h3010, 32'h0,    0, 0, 32'h0, 32'h3010, 0);
    step("jtype",     0, 3'd2, 0, 26'h0C40,   32'h3020, 32'h0,    0, 0, 32'h0, 32'h3100, 0);
    step("jreg",      0, 3'd3, 0, 26'h0,      32'h0,    32'h3abc, 0, 0, 32'h0, 32'h3abc, 0);

    // async reset between edges
    @(negedge clk); #1;
    reset = 1'b0;
    #1 check_now("async_reset", 32'h3000);
    @(negedge clk); #1;
    reset = 1'b1;
    drive_vec("jreg2", 0, 3'd3, 0, 26'h0, 32'h0, 32'h3abc, 0, 0, 32'h0, 32'h3abc, 0);

    step("stall_hold",  1, 3'd2, 0, 26'h0C40, 32'h3020, 32'h0, 0, 0, 32'h0,    32'h3abc, 0);
    step("stall_exc",   1, 3'd2, 0, 26'h0C40, 32'h3020, 32'h0, 1, 0, 32'h0,    32'h4180, 0);
    step("exc_eret",    0, 3'd0, 0, 26'h0,    32'h0,    32'h0, 1, 1, 32'h3040, 32'h4180, 0);
    step("eret",        0, 3'd0, 0, 26'h0,    32'h0,    32'h0, 0, 1, 32'h3040, 32'h3040, 0);
    step("cmp_ignored", 0, 3'd0, 1, 26'hFFFE, 32'h3010, 32'h0, 0, 0, 32'h0,    32'h3044, 0);
    step("mode_undef",  0, 3'd5, 1, 26'h0C40, 32'h3020, 32'h0, 0, 0, 32'h0,    32'h3048, 0);
    step("jtype_hi",    0, 3'd2, 0, 26'h3FFFFFF, 32'hA000_0000, 32'h0, 0, 0, 32'h0, 32'hAFFF_FFFC, 1);
    step("jreg_mis",    0, 3'd3, 0, 26'h0, 32'h0, 32'h3002, 0, 0, 32'h0, 32'h3002, 1);
    step("jreg_over",   0, 3'd3, 0, 26'h0, 32'h0, 32'h7000, 0, 0, 32'h0, 32'h7000, 1);
    step("jreg_top",    0, 3'd3, 0, 26'h0, 32'h0, 32'h6ffc, 0, 0, 32'h0, 32'h6ffc, 0);
    step("jreg_under",  0, 3'd3, 0, 26'h0, 32'h0, 32'h2ffc, 0, 0, 32'h0, 32'h2ffc, 1);
    step("jreg_bot",    0, 3'd3, 0, 26'h0, 32'h0, 32'h3000, 0, 0, 32'h0, 32'h3000, 0);
    step("stall_sh",    1, 3'd0, 0, 26'h0, 32'h0, 32'h0,    0, 0, 32'h0, 32'h3000, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
